// File: rtl/square_sweep_unit.sv
// Sweep unit for one APU square channel: owns the 11-bit period register and the
// sweep divider. Optional debug outputs sweep_div/sweep_upd under SQUARE_SWEEP_DEBUG_EN.
module square_sweep_unit #(
    parameter int unsigned PERIOD_W = 11,
    parameter int unsigned ONES_NEG = 1
) (
    input  logic                ACLK,
    input  logic                RES,
    input  logic                half_frame,
    input  logic                wr_sweep,
    input  logic                wr_lo,
    input  logic                wr_hi,
    input  logic [7:0]          din,
    output logic [PERIOD_W-1:0] freq,
    output logic [PERIOD_W-1:0] target,
    output logic                mute
`ifdef SQUARE_SWEEP_DEBUG_EN
    ,
    output logic [2:0]          sweep_div,
    output logic                sweep_upd
`endif
);

    localparam int unsigned DIV_W   = 3;
    localparam int unsigned SHIFT_W = 3;
    localparam int unsigned HI_W    = PERIOD_W - 8;
    localparam int unsigned SUM_W   = PERIOD_W + 1;

    logic [PERIOD_W-1:0] freq_q, freq_d;
    logic                en_q, en_d;
    logic [DIV_W-1:0]    per_q, per_d;
    logic                neg_q, neg_d;
    logic [SHIFT_W-1:0]  shift_q, shift_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                reload_q, reload_d;
    logic                upd_q;

    logic [PERIOD_W-1:0] sh;
    logic [PERIOD_W-1:0] addend;
    logic                cin;
    logic [SUM_W-1:0]    sum;
    logic                cout;
    logic                upd;

    // Target adder shared with the channel: negate is ~sh with a mode-dependent carry-in.
    always_comb begin
        sh     = freq_q >> shift_q;
        addend = neg_q ? ~sh : sh;
        cin    = neg_q && (ONES_NEG == 0);
        sum    = {1'b0, freq_q} + {1'b0, addend} + SUM_W'(cin);
        target = sum[PERIOD_W-1:0];
        cout   = sum[PERIOD_W];
        mute   = (freq_q < PERIOD_W'(8)) | (~neg_q & cout);
    end

    // Next state: sweep step on pre-edge state, then register writes override their bits.
    always_comb begin
        freq_d   = freq_q;
        en_d     = en_q;
        per_d    = per_q;
        neg_d    = neg_q;
        shift_d  = shift_q;
        div_d    = div_q;
        reload_d = reload_q;
        upd      = half_frame && (div_q == '0) && en_q && (shift_q != '0) && !mute;

        if (upd) begin
            freq_d = target;
        end
        if (half_frame) begin
            if ((div_q == '0) || reload_q) begin
                div_d    = per_q;
                reload_d = 1'b0;
            end else begin
                div_d = div_q - DIV_W'(1);
            end
        end
        if (wr_lo) begin
            freq_d[7:0] = din;
        end
        if (wr_hi) begin
            freq_d[PERIOD_W-1:8] = din[HI_W-1:0];
        end
        if (wr_sweep) begin
            en_d     = din[7];
            per_d    = din[6:4];
            neg_d    = din[3];
            shift_d  = din[2:0];
            reload_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (RES) begin
            freq_q   <= '0;
            en_q     <= 1'b0;
            per_q    <= '0;
            neg_q    <= 1'b0;
            shift_q  <= '0;
            div_q    <= '0;
            reload_q <= 1'b0;
            upd_q    <= 1'b0;
        end else begin
            freq_q   <= freq_d;
            en_q     <= en_d;
            per_q    <= per_d;
            neg_q    <= neg_d;
            shift_q  <= shift_d;
            div_q    <= div_d;
            reload_q <= reload_d;
            upd_q    <= upd;
        end
    end

    assign freq = freq_q;

`ifdef SQUARE_SWEEP_DEBUG_EN
    assign sweep_div = div_q;
    assign sweep_upd = upd_q;
`else
    logic unused_dbg;
    assign unused_dbg = upd_q;
`endif

endmodule

// File: tb/tb_square_sweep_unit.sv
// Bench for square_sweep_unit: both negate modes side by side, directed steps then random traffic.
module tb_square_sweep_unit;

    logic        ACLK = 1'b0;
    logic        RES = 1'b1;
    logic        half_frame = 1'b0;
    logic        wr_sweep = 1'b0;
    logic        wr_lo = 1'b0;
    logic        wr_hi = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [10:0] freq1, target1, freq2, target2;
    logic        mute1, mute2;
`ifdef SQUARE_SWEEP_DEBUG_EN
    logic [2:0]  div1, div2;
    logic        upd1, upd2;
`endif

    always #5 ACLK = ~ACLK;

    square_sweep_unit #(.PERIOD_W(11), .ONES_NEG(1)) u_sq1 (
        .ACLK(ACLK), .RES(RES), .half_frame(half_frame), .wr_sweep(wr_sweep),
        .wr_lo(wr_lo), .wr_hi(wr_hi), .din(din),
        .freq(freq1), .target(target1), .mute(mute1)
`ifdef SQUARE_SWEEP_DEBUG_EN
        , .sweep_div(div1), .sweep_upd(upd1)
`endif
    );

    square_sweep_unit #(.PERIOD_W(11), .ONES_NEG(0)) u_sq2 (
        .ACLK(ACLK), .RES(RES), .half_frame(half_frame), .wr_sweep(wr_sweep),
        .wr_lo(wr_lo), .wr_hi(wr_hi), .din(din),
        .freq(freq2), .target(target2), .mute(mute2)
`ifdef SQUARE_SWEEP_DEBUG_EN
        , .sweep_div(div2), .sweep_upd(upd2)
`endif
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Reference state; index 0 = ones'-complement channel, 1 = two's-complement channel.
    int m_freq[2];
    int m_en[2];
    int m_p[2];
    int m_neg[2];
    int m_s[2];
    int m_div[2];
    int m_reload[2];

    function automatic void m_eval(input int k, output int t, output bit mu);
        int sh;
        int full;
        bit ovf;
        sh  = m_freq[k] >> m_s[k];
        ovf = 1'b0;
        if (m_neg[k] != 0) begin
            t = (m_freq[k] - sh - ((k == 0) ? 1 : 0)) & 'h7FF;
        end else begin
            full = m_freq[k] + sh;
            ovf  = (full > 'h7FF);
            t    = full & 'h7FF;
        end
        mu = (m_freq[k] < 8) || ((m_neg[k] == 0) && ovf);
    endfunction

    task automatic m_step(input bit r, input bit h, input bit s, input bit l,
                          input bit hi, input logic [7:0] d);
        int t;
        bit mu;
        int nf;
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                m_freq[k] = 0; m_en[k] = 0; m_p[k] = 0; m_neg[k] = 0;
                m_s[k] = 0; m_div[k] = 0; m_reload[k] = 0;
            end else begin
                m_eval(k, t, mu);
                nf = m_freq[k];
                if (h) begin
                    if (m_div[k] == 0 && m_en[k] != 0 && m_s[k] != 0 && !mu) nf = t;
                    if (m_div[k] == 0 || m_reload[k] != 0) begin
                        m_div[k] = m_p[k];
                        m_reload[k] = 0;
                    end else begin
                        m_div[k] = m_div[k] - 1;
                    end
                end
                if (l)  nf = (nf & 'h700) | int'(d);
                if (hi) nf = (nf & 'h0FF) | (int'(d & 8'h07) << 8);
                m_freq[k] = nf;
                if (s) begin
                    m_en[k] = int'(d[7]); m_p[k] = int'(d[6:4]); m_neg[k] = int'(d[3]);
                    m_s[k] = int'(d[2:0]); m_reload[k] = 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int t;
        bit mu;
        m_eval(0, t, mu);
        chk("sq1_freq",   32'(freq1),   32'(m_freq[0]));
        chk("sq1_target", 32'(target1), 32'(t));
        chk("sq1_mute",   32'(mute1),   32'(mu));
        m_eval(1, t, mu);
        chk("sq2_freq",   32'(freq2),   32'(m_freq[1]));
        chk("sq2_target", 32'(target2), 32'(t));
        chk("sq2_mute",   32'(mute2),   32'(mu));
    endtask

    task automatic cyc(input bit r, input bit h, input bit s, input bit l,
                       input bit hi, input logic [7:0] d);
        RES = r; half_frame = h; wr_sweep = s; wr_lo = l; wr_hi = hi; din = d;
        @(posedge ACLK);
        m_step(r, h, s, l, hi, d);
        #1;
        check_all();
    endtask

    task automatic set_freq(input logic [10:0] v);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v[7:0]);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {5'b0, v[10:8]});
    endtask

    task automatic set_sweep(input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic hf();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    int exp_div[7] = '{'h060, 'h060, 'h060, 'h090, 'h090, 'h090, 'h0D8};

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_freq[k] = 0; m_en[k] = 0; m_p[k] = 0; m_neg[k] = 0;
            m_s[k] = 0; m_div[k] = 0; m_reload[k] = 0;
        end

        // Reset held with random strobes
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        chk("rst_freq", 32'(freq1), 32'h0);
        chk("rst_mute", 32'(mute1), 32'h1);
        chk("rst_target", 32'(target2), 32'h0);
        hf();
        chk("rst_hf_freq", 32'(freq2), 32'h0);

        // Add mode
        set_freq(11'h100);
        set_sweep(8'h81);
        chk("add_target", 32'(target1), 32'h180);
        chk("add_mute", 32'(mute1), 32'h0);
        hf();
        chk("add_freq", 32'(freq1), 32'h180);

        // Negate, both carry-in modes
        set_freq(11'h100);
        set_sweep(8'h89);
        chk("neg1_target", 32'(target1), 32'h07F);
        chk("neg2_target", 32'(target2), 32'h080);
        hf();
        chk("neg1_freq", 32'(freq1), 32'h07F);
        chk("neg2_freq", 32'(freq2), 32'h080);

        // Overflow mute
        set_freq(11'h600);
        set_sweep(8'h81);
        chk("ovf_mute", 32'(mute1), 32'h1);
        hf();
        chk("ovf_freq", 32'(freq1), 32'h600);

        // Low period mute, shift 0 no update
        set_freq(11'h005);
        chk("low_mute", 32'(mute2), 32'h1);
        set_freq(11'h200);
        set_sweep(8'h80);
        hf();
        chk("sh0_freq", 32'(freq1), 32'h200);
        chk("sh0_mute", 32'(mute1), 32'h0);

        // Divider P=2: updates on half-frames 1, 4, 7
        set_freq(11'h040);
        set_sweep(8'hA1);
        for (int i = 0; i < 7; i++) begin
            hf();
            chk("div_freq", 32'(freq1), 32'(exp_div[i]));
            idle(2);
        end
        hf();
        set_sweep(8'hA1);
        hf();
        hf();
        chk("restart_hold", 32'(freq1), 32'h0D8);
        hf();
        chk("restart_hold2", 32'(freq1), 32'h0D8);
        hf();
        chk("restart_upd", 32'(freq1), 32'h144);

        // Simultaneous write with sweep update
        set_freq(11'h100);
        set_sweep(8'h81);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h22);
        chk("wr_lo_hf", 32'(freq1), 32'h122);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/square_sweep_unit.md
Name: square_sweep_unit

Overview:
- Sequential sweep unit for one APU square channel.
- Owns the 11-bit channel period (frequency) register and the sweep divider/reload state.
- Derives the sweep target period using the same negate-with-carry arithmetic as the square channel adder.
- On half-frame clocks, writes the target back into the period register unless muted; also drives the channel mute condition.

Parameters:
- PERIOD_W, 11, width of period register and target arithmetic.
- ONES_NEG, 1, negate mode: 1 = Square1 (ones' complement, carry-in 0); 0 = Square2 (two's complement, carry-in 1).

Ports:
- ACLK  in  1  APU clock; all state changes on rising edge.
- RES  in  1  synchronous active-high reset.
- half_frame  in  1  one-cycle half-frame strobe from the frame counter.
- wr_sweep  in  1  write strobe, sweep register ($4001/$4005).
- wr_lo  in  1  write strobe, period low register ($4002/$4006).
- wr_hi  in  1  write strobe, period high register ($4003/$4007); only din[2:0] is used.
- din  in  8  register write data.
- freq  out  PERIOD_W  current channel period.
- target  out  PERIOD_W  sweep target period (combinational from current state).
- mute  out  1  channel silence request.

Behaviour:
- Sweep register fields: din[7] enable, din[6:4] divider period P, din[3] negate, din[2:0] shift s.
- Reset (RES=1 at edge):
  - freq=0, enable=0, P=0, negate=0, s=0, divider=0, reload=0.
  - mute=1, because freq<8.
  - RES overrides all strobes in the same cycle.
- Shift: sh = freq >> s; s=0 gives sh = freq.
- Addend:
  - negate=0: addend = sh, carry-in 0.
  - negate=1: addend = ~sh, carry-in = ~ONES_NEG.
- Sum and carry: {cout, target} = freq + addend + cin, computed to PERIOD_W+1 bits.
- Resulting target values:
  - ONES_NEG=1, negate=1: target = freq - sh - 1 (mod 2^11).
  - ONES_NEG=0, negate=1: target = freq - sh.
- Mute: mute = (freq < 8) | (~negate & cout). In negate mode cout is ignored.
- Register writes:
  - wr_lo loads freq[7:0].
  - wr_hi loads freq[10:8].
  - wr_sweep loads the fields and sets reload=1.
  - Writes take effect next cycle.
- Half-frame sequence (half_frame=1, evaluated on pre-edge state):
  1. If divider==0 && enable && s!=0 && !mute, then freq <= target.
  2. If divider==0 || reload, then divider <= P and reload <= 0; otherwise divider <= divider-1.
- Simultaneous events:
  - wr_lo/wr_hi together with a sweep update: the written byte wins for its bits. Untouched bits take target bits.
  - wr_sweep together with half_frame: the divider step uses the old P and old reload, then the new fields load and reload=1.
- Latency: freq updates one ACLK after the strobe; target and mute follow combinationally.
- Divider wrap: the divider never underflows, because it reloads at 0.
- Update period: a sweep update occurs every P+1 half-frames in steady state.

Optional Feature:
- Macro: SQUARE_SWEEP_DEBUG_EN.
- When defined:
  - Adds output port sweep_div (3 bits): the current divider value.
  - Adds output port sweep_upd (1 bit): a one-cycle pulse in the cycle after freq was loaded from target.
- When undefined: neither port exists and the logic is identical otherwise.

Test Plan:
- Reset: RES=1 for 2 cycles with random strobes asserted -> freq=0, mute=1, target=0; no update on half_frame.
- Add mode: freq=0x100, sweep din=0x81 (en, P=0, s=1), one half_frame -> target=0x180 before the strobe, freq=0x180 after, mute=0.
- Negate:
  - freq=0x100, din=0x89, ONES_NEG=1 -> target=0x07F.
  - Same setup with ONES_NEG=0 -> target=0x080.
  - One half_frame -> freq equals the respective target.
- Overflow mute: freq=0x600, din=0x81 -> cout=1, mute=1; half_frame leaves freq=0x600.
- Low-period mute and shift-0: freq=0x005 -> mute=1. freq=0x200 with din=0x80 (s=0) -> no update on half_frame, mute=0.
- Divider: din=0xA1 (P=2), freq=0x040 -> updates on half_frames 1, 4, 7 (0x040 -> 0x060 -> 0x090 -> 0x0D8). A wr_sweep between updates restarts the count.
